// File: rtl/reg_write_arbiter_if.sv
// Write-port bundle between the requesters and reg_write_arbiter.
// The lock vector exists only when ARB_LOCK_EN is defined.
interface reg_write_arbiter_if #(
   parameter int unsigned N_REQ  = 4,
   parameter int unsigned DATA_W = 32
);
   localparam int unsigned ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   logic [N_REQ-1:0]        req;
   logic [N_REQ*DATA_W-1:0] req_data;
`ifdef ARB_LOCK_EN
   logic [N_REQ-1:0]        lock;
`endif
   logic [N_REQ-1:0]        gnt;
   logic [ID_W-1:0]         gnt_id;
   logic                    reg_wr_en;
   logic [DATA_W-1:0]       reg_wdata;
   logic [15:0]             wr_count;

   modport master (
      output req, req_data,
`ifdef ARB_LOCK_EN
      output lock,
`endif
      input  gnt, gnt_id, reg_wr_en, reg_wdata, wr_count
   );

   modport slave (
      input  req, req_data,
`ifdef ARB_LOCK_EN
      input  lock,
`endif
      output gnt, gnt_id, reg_wr_en, reg_wdata, wr_count
   );
endinterface

// File: rtl/reg_write_arbiter.sv
// Round-robin write arbiter feeding one shared register's wr_en/data_in pins.
// Define ARB_LOCK_EN to add burst ownership (lock inputs, LOCKED state, MAX_BURST cap).
module reg_write_arbiter #(
   parameter int unsigned N_REQ     = 4,
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned MAX_BURST = 8
) (
   input logic               clk_sig,
   input logic               rst_sig,
   reg_write_arbiter_if.slave bus
);
   localparam int unsigned ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   logic [N_REQ-1:0]  gnt_q, gnt_d;
   logic [ID_W-1:0]   gnt_id_q, gnt_id_d;
   logic [ID_W-1:0]   ptr_q, ptr_d;
   logic              wr_en_q, wr_en_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [15:0]       cnt_q, cnt_d;

   logic [N_REQ-1:0]  elig;
   logic              win_vld;
   logic [ID_W-1:0]   win_id;
   logic [ID_W-1:0]   scan_id;
   int unsigned       scan_idx;

`ifdef ARB_LOCK_EN
   localparam int unsigned BURST_W = $clog2(MAX_BURST + 1);
   localparam logic ST_ARB    = 1'b0;
   localparam logic ST_LOCKED = 1'b1;

   logic               state_q, state_d;
   logic [ID_W-1:0]    owner_q, owner_d;
   logic [BURST_W-1:0] burst_q, burst_d;
   logic               keep_lock;
`endif

   // Winner selection: the current grantee is masked so a held request cannot win twice
   // in a row; scanning starts at ptr and wraps.
   always_comb begin
      elig     = bus.req & ~gnt_q;
      win_vld  = 1'b0;
      win_id   = '0;
      scan_idx = 0;
      scan_id  = '0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         scan_idx = (32'(ptr_q) + k) % N_REQ;
         scan_id  = ID_W'(scan_idx);
         if (!win_vld && elig[scan_id]) begin
            win_vld = 1'b1;
            win_id  = scan_id;
         end
      end
`ifdef ARB_LOCK_EN
      keep_lock = 1'b0;
      if (state_q == ST_LOCKED) begin
         keep_lock = bus.req[owner_q] & bus.lock[owner_q] &
                     (burst_q < BURST_W'(MAX_BURST));
      end
      // A continuing burst overrides the masked scan; on exit the scan result stands,
      // and the owner is still masked because its gnt is high this cycle.
      if (keep_lock) begin
         win_vld = 1'b1;
         win_id  = owner_q;
      end
`endif
   end

   always_comb begin
      gnt_d    = '0;
      wr_en_d  = win_vld;
      gnt_id_d = gnt_id_q;
      wdata_d  = wdata_q;
      ptr_d    = ptr_q;
      cnt_d    = cnt_q;
      if (win_vld) begin
         gnt_d[win_id] = 1'b1;
         gnt_id_d      = win_id;
         for (int unsigned i = 0; i < N_REQ; i++) begin
            if (win_id == ID_W'(i)) begin
               wdata_d = bus.req_data[i*DATA_W +: DATA_W];
            end
         end
         ptr_d = (win_id == ID_W'(N_REQ - 1)) ? '0 : win_id + 1'b1;
         cnt_d = cnt_q + 16'd1;
      end
   end

`ifdef ARB_LOCK_EN
   // The grant that enters LOCKED is the first grant of the burst.
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      burst_d = burst_q;
      if (keep_lock) begin
         burst_d = burst_q + BURST_W'(1);
      end else if (win_vld && bus.lock[win_id]) begin
         state_d = ST_LOCKED;
         owner_d = win_id;
         burst_d = BURST_W'(1);
      end else begin
         state_d = ST_ARB;
         burst_d = '0;
      end
   end

   always_ff @(posedge clk_sig or posedge rst_sig) begin
      if (rst_sig) begin
         state_q <= ST_ARB;
         owner_q <= '0;
         burst_q <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         burst_q <= burst_d;
      end
   end
`endif

   always_ff @(posedge clk_sig or posedge rst_sig) begin
      if (rst_sig) begin
         gnt_q    <= '0;
         gnt_id_q <= '0;
         ptr_q    <= '0;
         wr_en_q  <= 1'b0;
         wdata_q  <= '0;
         cnt_q    <= '0;
      end else begin
         gnt_q    <= gnt_d;
         gnt_id_q <= gnt_id_d;
         ptr_q    <= ptr_d;
         wr_en_q  <= wr_en_d;
         wdata_q  <= wdata_d;
         cnt_q    <= cnt_d;
      end
   end

   assign bus.gnt       = gnt_q;
   assign bus.gnt_id    = gnt_id_q;
   assign bus.reg_wr_en = wr_en_q;
   assign bus.reg_wdata = wdata_q;
   assign bus.wr_count  = cnt_q;
endmodule
